// File: rtl/irr_pkg.sv
// Shared types and small decode helpers for the irrigation zone controller.
package irr_pkg;

  typedef enum logic [1:0] {EMPTY = 2'd0, LOW = 2'd1, MED = 2'd2, FULL = 2'd3} level_t;
  typedef enum logic [1:0] {NONE = 2'd0, SPRINK = 2'd1, DRIP = 2'd2} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} zstate_t;

  function automatic int max3(input int a, input int b, input int c);
    int r;
    r = a;
    if (b > r) r = b;
    if (c > r) r = c;
    return r;
  endfunction

  // Invalid probe combinations fall through to EMPTY; callers qualify with level_bad().
  function automatic level_t decode_level(input logic h, input logic m, input logic l);
    level_t v;
    case ({h, m, l})
      3'b111:  v = FULL;
      3'b011:  v = MED;
      3'b001:  v = LOW;
      default: v = EMPTY;
    endcase
    return v;
  endfunction

  function automatic logic level_bad(input logic h, input logic m, input logic l);
    return (m & ~l) | (h & ~m);
  endfunction

  // Active-low {A,G,D}: D lit from LOW up, G from MED up, A only when FULL.
  function automatic logic [2:0] seg_pattern(input level_t lvl);
    logic [2:0] s;
    case (lvl)
      FULL:    s = 3'b000;
      MED:     s = 3'b100;
      LOW:     s = 3'b110;
      default: s = 3'b111;
    endcase
    return s;
  endfunction

  function automatic mode_t zone_mode(input logic sat, input logic moist, input logic hot,
                                      input level_t lvl);
    mode_t md;
    md = NONE;
    if (!sat && lvl != EMPTY) begin
      if (!moist)
        md = SPRINK;
      else if (!hot && (lvl == MED || lvl == FULL))
        md = SPRINK;
      else
        md = DRIP;
    end
    return md;
  endfunction

endpackage

// File: rtl/irrigation_zone_ctrl_if.sv
// Sensor pins in, valve / alarm / display drivers out, bundled for the zone controller.
interface irrigation_zone_ctrl_if #(
  parameter int N_ZONES = 2
);
  logic               h;
  logic               m;
  logic               l;
  logic               t;
  logic [N_ZONES-1:0] us;
  logic [N_ZONES-1:0] ua;
  logic               err_clr;
  logic               ve;
  logic [N_ZONES-1:0] bs;
  logic [N_ZONES-1:0] vs;
  logic               al;
  logic               erro;
  logic [2:0]         seg_n;

  modport master (
    output h, m, l, t, us, ua, err_clr,
    input  ve, bs, vs, al, erro, seg_n
  );

  modport slave (
    input  h, m, l, t, us, ua, err_clr,
    output ve, bs, vs, al, erro, seg_n
  );
endinterface

// File: rtl/irr_debounce.sv
// Two-flop synchroniser followed by a stability filter: output follows the
// synchronised input only after it has differed for DEB_CYCLES consecutive cycles.
module irr_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller: debounced sensors, tank fill with hysteresis,
// latched level-probe error, and a round-robin sprinkler/drip scheduler.
module irrigation_zone_ctrl
  import irr_pkg::*;
#(
  parameter int N_ZONES    = 2,
  parameter int DEB_CYCLES = 4,
  parameter int SPRINK_CYC = 1000,
  parameter int DRIP_CYC   = 3000,
  parameter int GAP_CYC    = 200
) (
  input logic                  clk,
  input logic                  rst_n,
  irrigation_zone_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(max3(SPRINK_CYC, DRIP_CYC, GAP_CYC) + 1);
  localparam int ZW     = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int SETTLE = DEB_CYCLES + 2;
  localparam int SW     = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] SPRINK_LD = CNT_W'(SPRINK_CYC - 1);
  localparam logic [CNT_W-1:0] DRIP_LD   = CNT_W'(DRIP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [ZW-1:0]    LAST_Z    = ZW'(N_ZONES - 1);

  logic               fh, fm, fl, ft;
  logic [N_ZONES-1:0] fus, fua;

  irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_h (.clk(clk), .rst_n(rst_n), .din(bus.h), .dout(fh));
  irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_m (.clk(clk), .rst_n(rst_n), .din(bus.m), .dout(fm));
  irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (.clk(clk), .rst_n(rst_n), .din(bus.l), .dout(fl));
  irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_t (.clk(clk), .rst_n(rst_n), .din(bus.t), .dout(ft));

  for (genvar g = 0; g < N_ZONES; g++) begin : g_zone_deb
    irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_us (
      .clk(clk), .rst_n(rst_n), .din(bus.us[g]), .dout(fus[g]));
    irr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ua (
      .clk(clk), .rst_n(rst_n), .din(bus.ua[g]), .dout(fua[g]));
  end

  // Filters start from 0 after reset; keep outputs and scheduler quiet until they have seen the pins.
  logic [SW-1:0] settle;
  logic          ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      ready  <= 1'b0;
    end else if (!ready) begin
      if (settle == SW'(SETTLE)) ready  <= 1'b1;
      else                       settle <= settle + 1'b1;
    end
  end

  level_t lvl;
  logic   lvl_bad;
  logic   err_nxt;
  logic   erro_q, ve_q, al_q;
  logic [2:0] seg_q;

  assign lvl     = decode_level(fh, fm, fl);
  assign lvl_bad = level_bad(fh, fm, fl);

  // A bad combination wins over a simultaneous clear request.
  always_comb begin
    err_nxt = erro_q;
    if (ready && lvl_bad)
      err_nxt = 1'b1;
    else if (bus.err_clr && !lvl_bad)
      err_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro_q <= 1'b0;
      ve_q   <= 1'b0;
      al_q   <= 1'b0;
      seg_q  <= 3'b111;
    end else begin
      erro_q <= err_nxt;
      ve_q   <= ready & ~err_nxt &
                ((lvl == LOW) | (lvl == EMPTY) | ((lvl == MED) & ve_q));
      al_q   <= ready & (err_nxt | (lvl == LOW) | (lvl == EMPTY));
      seg_q  <= (!ready || err_nxt) ? 3'b111 : seg_pattern(lvl);
    end
  end

  zstate_t          state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [ZW-1:0]    zone_q, zone_d;
  logic [ZW-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  logic             pick_ok;
  logic [ZW-1:0]    pick_zone;
  mode_t            pick_mode;
  logic [ZW-1:0]    idx;
  mode_t            cand;

  // Round-robin scan starting at the pointer; first zone with a watering mode wins.
  always_comb begin
    pick_ok   = 1'b0;
    pick_zone = rr_q;
    pick_mode = NONE;
    idx       = '0;
    cand      = NONE;
    for (int i = 0; i < N_ZONES; i++) begin
      idx  = ZW'((int'(rr_q) + i) % N_ZONES);
      cand = zone_mode(fus[idx], fua[idx], ft, lvl);
      if (!pick_ok && cand != NONE) begin
        pick_ok   = 1'b1;
        pick_zone = idx;
        pick_mode = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    zone_d  = zone_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (ready && !err_nxt && pick_ok) begin
          state_d = RUN;
          zone_d  = pick_zone;
          mode_d  = pick_mode;
          timer_d = (pick_mode == DRIP) ? DRIP_LD : SPRINK_LD;
        end
      end
      RUN: begin
        if (err_nxt || lvl == EMPTY || fus[zone_q] || timer_q == '0) begin
          state_d = GAP;
          mode_d  = NONE;
          timer_d = GAP_LD;
          rr_d    = (zone_q == LAST_Z) ? '0 : zone_q + 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= NONE;
      zone_q  <= '0;
      rr_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      zone_q  <= zone_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
    end
  end

  // Valves decode straight from state so an async reset shuts them immediately.
  logic [N_ZONES-1:0] bs_w, vs_w;

  always_comb begin
    bs_w = '0;
    vs_w = '0;
    if (state_q == RUN) begin
      if (mode_q == SPRINK)    bs_w[zone_q] = 1'b1;
      else if (mode_q == DRIP) vs_w[zone_q] = 1'b1;
    end
  end

  assign bus.bs    = bs_w;
  assign bus.vs    = vs_w;
  assign bus.ve    = ve_q;
  assign bus.al    = al_q;
  assign bus.erro  = erro_q;
  assign bus.seg_n = seg_q;

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Scenario bench for irrigation_zone_ctrl; valve sequences go through an expected-value queue.
module tb_irrigation_zone_ctrl;

  localparam int NZ   = 2;
  localparam int DEB  = 2;
  localparam int SPR  = 8;
  localparam int DRP  = 12;
  localparam int GAPC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irrigation_zone_ctrl_if #(.N_ZONES(NZ)) bus();

  irrigation_zone_ctrl #(
    .N_ZONES(NZ), .DEB_CYCLES(DEB), .SPRINK_CYC(SPR), .DRIP_CYC(DRP), .GAP_CYC(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];  // {bs, vs} per cycle

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.h = 1'b1; bus.m = 1'b1; bus.l = 1'b1; bus.t = 1'b0;
    bus.us = 2'b11; bus.ua = 2'b11; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (bus.seg_n !== 3'b111) begin
      errors++; $display("FAIL reset_seg got %b exp 111", bus.seg_n);
    end
    checks++;
    if ({bus.ve, bus.al, bus.erro, bus.bs, bus.vs} !== 7'b0) begin
      errors++; $display("FAIL reset_outs got %b exp 0", {bus.ve, bus.al, bus.erro, bus.bs, bus.vs});
    end
    rst_n = 1'b1;
    tick(10);
    checks++;
    if (bus.seg_n !== 3'b000) begin
      errors++; $display("FAIL full_seg got %b exp 000", bus.seg_n);
    end
    checks++;
    if ({bus.ve, bus.al, bus.erro, bus.bs, bus.vs} !== 7'b0) begin
      errors++; $display("FAIL full_outs got %b exp 0", {bus.ve, bus.al, bus.erro, bus.bs, bus.vs});
    end
  endtask

  task automatic test_fill();
    bus.h = 1'b0; bus.m = 1'b0;
    tick(8);
    checks++;
    if ({bus.ve, bus.al, bus.seg_n} !== 5'b11_110) begin
      errors++; $display("FAIL fill_low got %b exp 11110", {bus.ve, bus.al, bus.seg_n});
    end
    bus.m = 1'b1;
    tick(8);
    checks++;
    if ({bus.ve, bus.al, bus.seg_n} !== 5'b10_100) begin
      errors++; $display("FAIL fill_med_hold got %b exp 10100", {bus.ve, bus.al, bus.seg_n});
    end
    bus.h = 1'b1;
    tick(8);
    checks++;
    if ({bus.ve, bus.al, bus.seg_n} !== 5'b00_000) begin
      errors++; $display("FAIL fill_full got %b exp 00000", {bus.ve, bus.al, bus.seg_n});
    end
  endtask

  task automatic test_level_error();
    bus.h = 1'b0; bus.m = 1'b0;
    tick(8);
    checks++;
    if (bus.ve !== 1'b1) begin
      errors++; $display("FAIL err_pre_ve got %b exp 1", bus.ve);
    end
    bus.m = 1'b1; bus.l = 1'b0;
    tick(1);
    bus.m = 1'b0; bus.l = 1'b1;
    tick(8);
    checks++;
    if ({bus.erro, bus.ve} !== 2'b01) begin
      errors++; $display("FAIL glitch_ignored got %b exp 01", {bus.erro, bus.ve});
    end
    bus.m = 1'b1; bus.l = 1'b0;
    tick(8);
    checks++;
    if ({bus.erro, bus.ve, bus.al, bus.seg_n} !== 6'b101_111) begin
      errors++; $display("FAIL err_set got %b exp 101111", {bus.erro, bus.ve, bus.al, bus.seg_n});
    end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(2);
    checks++;
    if (bus.erro !== 1'b1) begin
      errors++; $display("FAIL err_clr_while_bad got %b exp 1", bus.erro);
    end
    bus.m = 1'b0; bus.l = 1'b1;
    tick(8);
    checks++;
    if ({bus.erro, bus.ve} !== 2'b10) begin
      errors++; $display("FAIL err_sticky got %b exp 10", {bus.erro, bus.ve});
    end
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(2);
    checks++;
    if ({bus.erro, bus.ve, bus.seg_n} !== 5'b01_110) begin
      errors++; $display("FAIL err_cleared got %b exp 01110", {bus.erro, bus.ve, bus.seg_n});
    end
    bus.h = 1'b1; bus.m = 1'b1;
    tick(8);
    checks++;
    if (bus.ve !== 1'b0) begin
      errors++; $display("FAIL err_refull_ve got %b exp 0", bus.ve);
    end
  endtask

  task automatic test_round_robin();
    int n;
    bus.h = 1'b0;
    tick(8);
    bus.us = 2'b00; bus.ua = 2'b00;
    n = 0;
    while (bus.bs === 2'b00 && n < 20) begin tick(1); n++; end
    checks++;
    if (bus.bs === 2'b00) begin
      errors++; $display("FAIL rr_start timeout got bs=%b exp nonzero", bus.bs);
    end
    repeat (SPR)      exp_q.push_back(4'b0100);
    repeat (GAPC + 1) exp_q.push_back(4'b0000);
    repeat (SPR)      exp_q.push_back(4'b1000);
    repeat (GAPC + 1) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0100);
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.bs, bus.vs} !== e) begin
        errors++; $display("FAIL rr_seq got %b exp %b", {bus.bs, bus.vs}, e);
      end
      tick(1);
    end
    bus.us = 2'b11;
    tick(12);
  endtask

  task automatic test_drip_abort();
    int n;
    bus.us = 2'b10; bus.ua = 2'b11; bus.t = 1'b1;
    n = 0;
    while (bus.vs === 2'b00 && n < 20) begin tick(1); n++; end
    checks++;
    if (bus.vs === 2'b00) begin
      errors++; $display("FAIL drip_start timeout got vs=%b exp nonzero", bus.vs);
    end
    repeat (DRP)      exp_q.push_back(4'b0001);
    repeat (GAPC + 1) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.bs, bus.vs} !== e) begin
        errors++; $display("FAIL drip_seq got %b exp %b", {bus.bs, bus.vs}, e);
      end
      tick(1);
    end
    tick(2);
    bus.us = 2'b11;
    n = 0;
    while (bus.vs !== 2'b00 && n < 12) begin tick(1); n++; end
    checks++;
    if (bus.vs !== 2'b00 || n > DEB + 3) begin
      errors++; $display("FAIL drip_abort got vs=%b after %0d cycles exp 00 within %0d", bus.vs, n, DEB + 3);
    end
    tick(GAPC + 5);
    checks++;
    if ({bus.bs, bus.vs} !== 4'b0000) begin
      errors++; $display("FAIL drip_saturated_idle got %b exp 0000", {bus.bs, bus.vs});
    end
    bus.t = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    bus.us = 2'b00; bus.ua = 2'b00;
    n = 0;
    while (bus.bs === 2'b00 && n < 20) begin tick(1); n++; end
    checks++;
    if (bus.bs !== 2'b10) begin
      errors++; $display("FAIL rr_after_abort got bs=%b exp 10", bus.bs);
    end
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bs, bus.vs} !== 4'b0000) begin
      errors++; $display("FAIL async_reset_valves got %b exp 0000", {bus.bs, bus.vs});
    end
    tick(2);
    rst_n = 1'b1;
    n = 0;
    while (bus.bs === 2'b00 && n < 30) begin tick(1); n++; end
    checks++;
    if (bus.bs !== 2'b01) begin
      errors++; $display("FAIL restart_zone0 got bs=%b exp 01", bus.bs);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_level_error();
    test_round_robin();
    test_drip_abort();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
